// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models MD latency, stalls younger MD ops.
// Optional build macro MD_CANCEL_EN adds Req_Cancel to abort a start or an operation in flight.
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  input  logic        D_UseMD,
`ifdef MD_CANCEL_EN
  input  logic        Req_Cancel,
`endif
  output logic        E_Start,
  output logic        E_Busy,
  output logic        MD_Stall,
  output logic [31:0] E_MDOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [DATA_W-1:0]  sh_hi_q, sh_hi_d;
  logic [DATA_W-1:0]  sh_lo_q, sh_lo_d;
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0]  lo_q, lo_d;
  logic               cancel;

`ifdef MD_CANCEL_EN
  assign cancel = Req_Cancel;
`else
  assign cancel = 1'b0;
`endif

  // Full-width products; signed operands are sign-extended to 64 bits first.
  logic [2*DATA_W-1:0] prod_s, prod_u;
  assign prod_s = $signed({{DATA_W{E_RS[DATA_W-1]}}, E_RS}) * $signed({{DATA_W{E_RT[DATA_W-1]}}, E_RT});
  assign prod_u = {{DATA_W{1'b0}}, E_RS} * {{DATA_W{1'b0}}, E_RT};

  // Signed divide via magnitudes: avoids the -2^31/-1 overflow and gives truncation toward zero.
  logic              div_signed, rs_neg, rt_neg;
  logic [DATA_W-1:0] div_a, div_b, div_b_safe, uquot, urem, quot, rem;
  assign div_signed = (E_MDOp == OP_DIV);
  assign rs_neg     = div_signed & E_RS[DATA_W-1];
  assign rt_neg     = div_signed & E_RT[DATA_W-1];
  assign div_a      = rs_neg ? (~E_RS + DATA_W'(1)) : E_RS;
  assign div_b      = rt_neg ? (~E_RT + DATA_W'(1)) : E_RT;
  assign div_b_safe = (div_b == '0) ? DATA_W'(1) : div_b;
  assign uquot      = div_a / div_b_safe;
  assign urem       = div_a % div_b_safe;
  assign quot       = (rs_neg ^ rt_neg) ? (~uquot + DATA_W'(1)) : uquot;
  assign rem        = rs_neg ? (~urem + DATA_W'(1)) : urem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state, shadow capture and HI/LO commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    E_Start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!cancel) begin
          case (E_MDOp)
            OP_MULT, OP_MULTU: begin
              E_Start            = 1'b1;
              {sh_hi_d, sh_lo_d} = (E_MDOp == OP_MULT) ? prod_s : prod_u;
              cnt_d              = CNT_W'(MULT_CYCLES);
              state_d            = S_MULT;
            end
            OP_DIV, OP_DIVU: begin
              E_Start = 1'b1;
              if (E_RT == '0) begin
                sh_hi_d = hi_q;
                sh_lo_d = lo_q;
              end else begin
                sh_hi_d = rem;
                sh_lo_d = quot;
              end
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = S_DIV;
            end
            OP_MTHI: hi_d = E_RS;
            OP_MTLO: lo_d = E_RS;
            default: ;
          endcase
        end
      end
      S_MULT, S_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    case (E_MDOp)
      OP_MFHI: E_MDOut = hi_q;
      OP_MFLO: E_MDOut = lo_q;
      default: E_MDOut = '0;
    endcase
  end

  assign E_Busy   = busy_q;
  assign MD_Stall = D_UseMD & (E_Start | busy_q);
  assign HI       = hi_q;
  assign LO       = lo_q;

  // Pipeline stalls keep starts and HI/LO moves out of E while an operation is in flight.
  a_no_md_write_while_busy: assert property (@(posedge clk) disable iff (!reset)
    busy_q |-> !((E_MDOp >= OP_MULT) && (E_MDOp <= OP_MTLO)));

endmodule

// File: tb/tb_md_scheduler.sv
// Randomized self-checking bench for md_scheduler against a cycle-level behavioural model.
module tb_md_scheduler;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDOp;
  logic [31:0] E_RS, E_RT;
  logic        D_UseMD;
`ifdef MD_CANCEL_EN
  logic        Req_Cancel;
`endif
  logic        E_Start, E_Busy, MD_Stall;
  logic [31:0] E_MDOut, HI, LO;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_rem;

  md_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .E_MDOp    (E_MDOp),
    .E_RS      (E_RS),
    .E_RT      (E_RT),
    .D_UseMD   (D_UseMD),
`ifdef MD_CANCEL_EN
    .Req_Cancel(Req_Cancel),
`endif
    .E_Start   (E_Start),
    .E_Busy    (E_Busy),
    .MD_Stall  (MD_Stall),
    .E_MDOut   (E_MDOut),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_start(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic signed [63:0] a, b, p, q, r;
    logic [63:0] u;
    m_phi = m_hi;
    m_plo = m_lo;
    case (op)
      4'd1: begin
        a = $signed(rs); b = $signed(rt); p = a * b;
        m_phi = p[63:32]; m_plo = p[31:0];
      end
      4'd2: begin
        u = 64'(rs) * 64'(rt);
        m_phi = u[63:32]; m_plo = u[31:0];
      end
      4'd3: if (rt != 32'd0) begin
        a = $signed(rs); b = $signed(rt); q = a / b; r = a % b;
        m_plo = q[31:0]; m_phi = r[31:0];
      end
      4'd4: if (rt != 32'd0) begin
        m_plo = rs / rt; m_phi = rs % rt;
      end
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_rem = 0;
  endfunction

  // One pipeline cycle: drive at negedge, check mid-cycle, advance the model at posedge.
  task automatic cycle(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic duse, input logic cancel);
    logic busy, start;
    logic [31:0] exp_out;
    @(negedge clk);
    E_MDOp = op; E_RS = rs; E_RT = rt; D_UseMD = duse;
`ifdef MD_CANCEL_EN
    Req_Cancel = cancel;
`endif
    #1;
    busy    = (m_rem != 0);
    start   = (op >= 4'd1) && (op <= 4'd4) && !busy && !cancel;
    exp_out = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    check("busy",  E_Busy,   busy);
    check("start", E_Start,  start);
    check("stall", MD_Stall, duse && (start || busy));
    check("mdout", E_MDOut,  exp_out);
    check("hi",    HI,       m_hi);
    check("lo",    LO,       m_lo);
    @(posedge clk);
    if (busy) begin
      if (cancel) m_rem = 0;
      else begin
        m_rem--;
        if (m_rem == 0) begin m_hi = m_phi; m_lo = m_plo; end
      end
    end else if (!cancel) begin
      if (start) begin
        model_start(op, rs, rt);
        m_rem = (op <= 4'd2) ? MC : DC;
      end else if (op == 4'd5) m_hi = rs;
      else if (op == 4'd6) m_lo = rs;
    end
  endtask

  task automatic idle(input int n, input logic duse);
    for (int i = 0; i < n; i++) cycle(4'd0, 32'd0, 32'd0, duse, 1'b0);
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic pulse_reset();
    @(negedge clk);
    E_MDOp = 4'd0; D_UseMD = 1'b0;
`ifdef MD_CANCEL_EN
    Req_Cancel = 1'b0;
`endif
    #2 reset = 1'b0;
    #1;
    check("rst_busy", E_Busy, 1'b0);
    check("rst_hi",   HI,     32'd0);
    check("rst_lo",   LO,     32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic rand_cancel();
`ifdef MD_CANCEL_EN
    return ($urandom_range(0, 15) == 0);
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    logic [3:0]  op;
    logic [31:0] rt;
    reset = 1'b0; E_MDOp = 4'd0; E_RS = '0; E_RT = '0; D_UseMD = 1'b1;
`ifdef MD_CANCEL_EN
    Req_Cancel = 1'b0;
`endif
    model_reset();
    #12;
    check("init_hi",    HI,       32'd0);
    check("init_lo",    LO,       32'd0);
    check("init_busy",  E_Busy,   1'b0);
    check("init_stall", MD_Stall, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    idle(1, 1'b1);

    // MULT / MULTU with -1 (0xFFFFFFFF) x 2
    cycle(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    idle(MC, 1'b0);
    #1;
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);
    cycle(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    idle(MC, 1'b0);
    #1;
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    // DIV -7/2, then DIVU by zero leaves HI/LO alone
    cycle(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(DC, 1'b0);
    #1;
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    cycle(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
    idle(DC, 1'b0);
    #1;
    check("divz_hi", HI, 32'hFFFF_FFFF);
    check("divz_lo", LO, 32'hFFFF_FFFD);

    // -2^31 / -1 overflow case
    cycle(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(DC, 1'b0);
    #1;
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'd0);

    // MFLO directly behind MULT stalls through the start cycle and all busy cycles
    cycle(4'd1, 32'd3, 32'd4, 1'b1, 1'b0);
    idle(MC, 1'b1);
    cycle(4'd8, 32'd0, 32'd0, 1'b1, 1'b0);
    #1;
    check("mflo_out", E_MDOut, 32'd12);

    // MTHI while idle, then MFHI
    cycle(4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    #1;
    check("mthi_hi",   HI,     32'h1234_5678);
    check("mthi_busy", E_Busy, 1'b0);
    cycle(4'd7, 32'd0, 32'd0, 1'b1, 1'b0);
    #1;
    check("mfhi_out", E_MDOut, 32'h1234_5678);

    // Reset in the 4th cycle of a DIV
    cycle(4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    idle(3, 1'b0);
    pulse_reset();
    idle(2, 1'b0);

`ifdef MD_CANCEL_EN
    cycle(4'd5, 32'hAAAA_0001, 32'd0, 1'b0, 1'b0);
    cycle(4'd6, 32'hBBBB_0002, 32'd0, 1'b0, 1'b0);
    cycle(4'd1, 32'd9, 32'd9, 1'b0, 1'b0);
    idle(2, 1'b0);
    cycle(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    #1;
    check("cancel_busy", E_Busy, 1'b0);
    check("cancel_hi",   HI,     32'hAAAA_0001);
    check("cancel_lo",   LO,     32'hBBBB_0002);
    cycle(4'd5, 32'd5, 32'd0, 1'b0, 1'b1);
    cycle(4'd3, 32'd5, 32'd1, 1'b1, 1'b1);
    idle(2, 1'b0);
`endif

    // Random traffic; MD writes only offered while the model is idle
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      if (m_rem != 0) begin
        case ($urandom_range(0, 3))
          0: op = 4'd0;
          1: op = 4'd7;
          2: op = 4'd8;
          default: op = 4'(9 + $urandom_range(0, 6));
        endcase
      end else begin
        op = 4'($urandom_range(0, 15));
      end
      rt = ($urandom_range(0, 5) == 0) ? 32'd0 : rand_word();
      cycle(op, rand_word(), rt, 1'($urandom_range(0, 1)), rand_cancel());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
